// File: rtl/rv_credit_sender.sv
// rv_credit_sender: transmit end of a credit-based link.
// Takes a valid/ready stream from upstream and forwards each accepted beat
// over a valid-only link. A beat is sent only while a receiver credit is
// held; every credit_return pulse hands one credit back. ready_in comes
// straight from the credit register, so the long link wire never sits on
// a combinational ready path.
module rv_credit_sender #(
  parameter int DATAW   = 1,
  parameter int CREDITS = 4,
  parameter int OUT_REG = 0,
  parameter int CNTW    = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             tx_valid,
  output logic [DATAW-1:0] tx_data,
  input  logic             credit_return,
  output logic [CNTW-1:0]  credits,
  output logic             idle,
  output logic             overflow
);

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(CREDITS);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;
  logic            send;
  logic            ovf_q;
  logic            ovf_set;
  logic            cnt_full;

  // Credit is consumed at the upstream handshake, not when the beat hits
  // the link, so ready_in can only ever depend on the registered count.
  assign ready_in = (cnt != '0);
  assign send     = valid_in & ready_in;
  assign cnt_full = (cnt == CNT_FULL);
  assign credits  = cnt;
  assign overflow = ovf_q;

  // Next credit count; a return into a full counter saturates and flags.
  always_comb begin
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    case ({send, credit_return})
      2'b10: cnt_nxt = cnt - CNT_ONE;
      2'b01: begin
        if (cnt_full) ovf_set = 1'b1;
        else          cnt_nxt = cnt + CNT_ONE;
      end
      default: cnt_nxt = cnt;
    endcase
  end

  // Credit counter and sticky overflow; returns seen during reset are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= CNT_FULL;
      ovf_q <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic             tx_valid_q;
      logic [DATAW-1:0] tx_data_q;

      // One-cycle output register; data only moves on a send so the link
      // payload holds between beats.
      always_ff @(posedge clk) begin
        if (reset) begin
          tx_valid_q <= 1'b0;
          tx_data_q  <= '0;
        end else begin
          tx_valid_q <= send;
          if (send) tx_data_q <= data_in;
        end
      end

      assign tx_valid = tx_valid_q;
      assign tx_data  = tx_data_q;
      // A beat still sitting in the output register means not drained.
      assign idle     = cnt_full & ~tx_valid_q;
    end else begin : g_comb
      assign tx_valid = send;
      assign tx_data  = data_in;
      assign idle     = cnt_full;
    end
  endgenerate

endmodule

// File: tb/tb_rv_credit_sender.sv
// Directed bench for rv_credit_sender: one combinational-output instance
// and one registered-output instance, both CREDITS=4, DATAW=8.
module tb_rv_credit_sender;

  logic       clk;
  logic       rst;
  logic       v0, cr0, v1, cr1;
  logic [7:0] d0, d1;
  logic       r0, tv0, idle0, ov0;
  logic       r1, tv1, idle1, ov1;
  logic [7:0] td0, td1;
  logic [2:0] cred0, cred1;

  int tests = 0;
  int fails = 0;

  rv_credit_sender #(.DATAW(8), .CREDITS(4), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(rst), .valid_in(v0), .data_in(d0), .ready_in(r0),
    .tx_valid(tv0), .tx_data(td0), .credit_return(cr0), .credits(cred0),
    .idle(idle0), .overflow(ov0)
  );

  rv_credit_sender #(.DATAW(8), .CREDITS(4), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(rst), .valid_in(v1), .data_in(d1), .ready_in(r1),
    .tx_valid(tv1), .tx_data(td1), .credit_return(cr1), .credits(cred1),
    .idle(idle1), .overflow(ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [1:0] hist;
    rst = 1'b1; v0 = 1'b0; cr0 = 1'b0; d0 = 8'h00;
    v1 = 1'b0; cr1 = 1'b0; d1 = 8'h00;
    tick(); tick();
    rst = 1'b0;
    #1;
    // reset state
    chk("rst_cred0", 32'(cred0), 32'd4);
    chk("rst_rdy0",  32'(r0),    32'd1);
    chk("rst_tv0",   32'(tv0),   32'd0);
    chk("rst_idle0", 32'(idle0), 32'd1);
    chk("rst_ovf0",  32'(ov0),   32'd0);
    chk("rst_cred1", 32'(cred1), 32'd4);
    chk("rst_rdy1",  32'(r1),    32'd1);
    chk("rst_tv1",   32'(tv1),   32'd0);
    chk("rst_td1",   32'(td1),   32'd0);
    chk("rst_idle1", 32'(idle1), 32'd1);
    chk("rst_ovf1",  32'(ov1),   32'd0);

    // exhaust credits: exactly four beats 1..4
    v0 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d0 = 8'(i);
      #1;
      chk("drain_cred", 32'(cred0), 32'(5 - i));
      chk("drain_tv",   32'(tv0),   32'd1);
      chk("drain_td",   32'(td0),   32'(i));
      tick();
    end
    d0 = 8'h05;
    #1;
    chk("empty_cred", 32'(cred0), 32'd0);
    chk("empty_rdy",  32'(r0),    32'd0);
    chk("empty_tv",   32'(tv0),   32'd0);
    chk("empty_idle", 32'(idle0), 32'd0);

    // single credit back -> exactly one more beat
    cr0 = 1'b1;
    #1;
    chk("ret_cycle_tv", 32'(tv0), 32'd0);
    tick();
    cr0 = 1'b0;
    #1;
    chk("one_cred", 32'(cred0), 32'd1);
    chk("one_rdy",  32'(r0),    32'd1);
    chk("one_tv",   32'(tv0),   32'd1);
    chk("one_td",   32'(td0),   32'h05);
    tick();
    chk("one_rdy_after",  32'(r0),    32'd0);
    chk("one_cred_after", 32'(cred0), 32'd0);

    // build up to 2 credits, then send and return together
    v0 = 1'b0; cr0 = 1'b1;
    tick(); tick();
    v0 = 1'b1; d0 = 8'h06;
    #1;
    chk("sim_pre_cred", 32'(cred0), 32'd2);
    chk("sim_tv",       32'(tv0),   32'd1);
    tick();
    v0 = 1'b0;
    #1;
    chk("sim_cred", 32'(cred0), 32'd2);
    tick(); tick();
    #1;
    chk("full_cred", 32'(cred0), 32'd4);
    chk("full_ovf",  32'(ov0),   32'd0);
    // one more return at full -> saturate and flag
    tick();
    cr0 = 1'b0;
    #1;
    chk("ovf_cred", 32'(cred0), 32'd4);
    chk("ovf_set",  32'(ov0),   32'd1);
    tick(); tick();
    chk("ovf_sticky", 32'(ov0), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("ovf_clr", 32'(ov0), 32'd0);

    // loopback: return each credit two cycles after its send, 100 beats
    hist = 2'b00;
    for (int cyc = 0; cyc < 102; cyc++) begin
      v0  = (cyc < 100);
      d0  = 8'(cyc);
      cr0 = hist[1];
      #1;
      if (cyc < 100) begin
        chk("lb_tv",   32'(tv0),   32'd1);
        chk("lb_td",   32'(td0),   32'(cyc));
        chk("lb_cred", 32'(cred0), (cyc == 0) ? 32'd4 : (cyc == 1) ? 32'd3 : 32'd2);
      end
      hist = {hist[0], tv0};
      tick();
    end
    v0 = 1'b0; cr0 = 1'b0;
    #1;
    chk("lb_end_cred", 32'(cred0), 32'd4);
    chk("lb_end_idle", 32'(idle0), 32'd1);
    chk("lb_end_ovf",  32'(ov0),   32'd0);

    // registered output: beat appears one cycle later, only once
    v1 = 1'b1; d1 = 8'hA5;
    #1;
    chk("oreg_n_tv", 32'(tv1), 32'd0);
    tick();
    v1 = 1'b0; d1 = 8'h00;
    #1;
    chk("oreg_n1_tv",   32'(tv1),   32'd1);
    chk("oreg_n1_td",   32'(td1),   32'hA5);
    chk("oreg_n1_cred", 32'(cred1), 32'd3);
    chk("oreg_n1_idle", 32'(idle1), 32'd0);
    tick();
    chk("oreg_n2_tv",   32'(tv1),   32'd0);
    chk("oreg_n2_td",   32'(td1),   32'hA5);
    chk("oreg_n2_idle", 32'(idle1), 32'd0);
    cr1 = 1'b1;
    tick();
    cr1 = 1'b0;
    #1;
    chk("oreg_ret_cred", 32'(cred1), 32'd4);
    chk("oreg_ret_idle", 32'(idle1), 32'd1);

    // reset with credits=1 and a beat pending; return during reset ignored
    v1 = 1'b1;
    d1 = 8'h01; tick();
    d1 = 8'h02; tick();
    d1 = 8'h03; tick();
    v1 = 1'b0;
    #1;
    chk("pend_cred", 32'(cred1), 32'd1);
    chk("pend_tv",   32'(tv1),   32'd1);
    chk("pend_td",   32'(td1),   32'h03);
    chk("pend_idle", 32'(idle1), 32'd0);
    rst = 1'b1; cr1 = 1'b1;
    tick();
    rst = 1'b0; cr1 = 1'b0;
    #1;
    chk("mrst_tv",   32'(tv1),   32'd0);
    chk("mrst_td",   32'(td1),   32'd0);
    chk("mrst_cred", 32'(cred1), 32'd4);
    chk("mrst_idle", 32'(idle1), 32'd1);
    chk("mrst_ovf",  32'(ov1),   32'd0);
    // stale credit after reset is an overflow
    cr1 = 1'b1;
    tick();
    cr1 = 1'b0;
    #1;
    chk("stale_ovf",  32'(ov1),   32'd1);
    chk("stale_cred", 32'(cred1), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_credit_sender.md
# rv_credit_sender

Transmit end of a credit-based link whose receive end is an elastic buffer of depth CREDITS. It accepts a valid/ready stream from upstream and forwards beats over a valid-only link with no backpressure. It sends a beat only when a credit is held, and regains one credit per `credit_return` pulse from the receiver each time the receiver pops an entry. It sits between a GPU core request port and a remote elastic buffer in a different pipeline stage or partition, so the long wire needs no combinational ready path.

## Interface
- DATAW, 1, payload width in bits.
- CREDITS, 4, receiver buffer depth; must equal the receiver's SIZE; legal range is ≥1.
- OUT_REG, 0, 0 = `tx_valid`/`tx_data` combinational from the input; 1 = registered, adding one cycle of latency.
- CNTW, $clog2(CREDITS+1), width of the credit counter (derived; do not override).

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  upstream beat valid.
- data_in  in  DATAW  upstream payload.
- ready_in  out  1  upstream may transfer; a beat transfers when valid_in && ready_in.
- tx_valid  out  1  link beat valid; the receiver must always accept it.
- tx_data  out  DATAW  link payload.
- credit_return  in  1  one-cycle pulse per receiver pop; multiple pulses may arrive back-to-back.
- credits  out  CNTW  current credit count, taken directly from the register.
- idle  out  1  credits == CREDITS and no registered beat is pending; used for drain/flush checks.
- overflow  out  1  sticky error flag: a credit was returned while the counter was already full.

## Operation
- Credit counter `cnt` resets to CREDITS.
- `send` = valid_in && ready_in; `ready_in` = (cnt != 0).
- `ready_in` depends only on the registered `cnt`. There is no combinational path from `credit_return` or `valid_in` to `ready_in`.
- Counter update per cycle:
  - send only: cnt−1.
  - credit_return only: cnt+1.
  - both: unchanged.
  - neither: unchanged.
- credit_return with cnt == CREDITS and no send in the same cycle: cnt holds at CREDITS (saturates) and `overflow` sets. `overflow` clears only on reset.
- send with cnt == 0 cannot occur, because ready_in is 0.
- OUT_REG=0: tx_valid = send; tx_data = data_in. `idle` = (cnt == CREDITS).
- OUT_REG=1: registers tx_valid_q <= send and tx_data_q <= data_in when send. tx_valid_q clears the cycle after its beat is presented. `idle` = (cnt == CREDITS) && !tx_valid_q.
- The credit is consumed at transfer time, not at link-presentation time.
- tx_data holds its previous value when tx_valid = 0; it is not required to be zero.
- Ordering: beats leave in exactly the order they are accepted; there is no reordering and no drop.

## Timing
- Reset values:
  - cnt = CREDITS, credits = CREDITS.
  - ready_in = 1 (CREDITS ≥ 1).
  - tx_valid = 0, tx_data = 0 (OUT_REG=1).
  - idle = 1, overflow = 0.
- Latency from upstream transfer to link beat: 0 cycles for OUT_REG=0; 1 cycle for OUT_REG=1.
- Throughput: one beat per cycle while cnt > 0. Steady-state full rate requires a round trip of ≤ CREDITS cycles.
- A credit_return in cycle N is visible in `credits` and `ready_in` in cycle N+1.
- A send in cycle N drops `credits` in cycle N+1. If this consumes the last credit, ready_in = 0 in cycle N+1.
- Reset mid-operation, on the cycle after reset asserts:
  - cnt = CREDITS and any registered beat is discarded.
  - credit_return pulses arriving during reset are ignored.
  - The receiver must be reset in the same cycle. A stale credit arriving after reset is an overflow.
- Beats are presented once; nothing is replayed.

## Test plan
- Reset, then valid_in held high with CREDITS=4 and no credit_return -> exactly 4 beats transfer (data 0x1..0x4). ready_in falls the cycle after the 4th beat; credits reads 4,3,2,1,0.
- From credits=0, pulse credit_return once -> in the next cycle credits=1 and ready_in=1. One beat transfers, then ready_in=0 again.
- Continuous valid_in with credit_return looped back after 2 cycles, CREDITS=4 -> 1 beat/cycle sustained over 100 beats. Data order is preserved and credits never reaches 0.
- Simultaneous send and credit_return at credits=2 -> credits stays 2. At credits=4, credit_return with no send -> credits stays 4 and overflow=1, which persists until reset.
- OUT_REG=1: valid_in pulse with data 0xA5 at cycle N -> tx_valid=1, tx_data=0xA5 at cycle N+1 only. idle=0 at N+1 and stays 0 until the credit returns.
- Reset asserted with credits=1 and a registered beat pending -> next cycle tx_valid=0, credits=4, idle=1, overflow=0.
